dclk_tx_sched: RTL

DCLK_TX_SCHED -- requirements
Module: dclk_tx_sched

---
 rtl/dclk_tx_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dclk_tx_sched.sv
// Round-robin scheduler: arbitrates NREQ flit requesters onto one serial transmitter.
// Flit width comes from the shared width macros; defaults give an 8-bit flit.
`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

// state   | meaning
// S_IDLE  | waiting for an enabled request; grants round-robin on the edge one is seen
// S_ISSUE | tx_req high with the latched flit; accepted at the first edge with tx_busy low
// S_HOLD  | ack pulse out; waits for tx_busy low before allowing the next grant
module dclk_tx_sched #(
   parameter  int NREQ = 4,
   localparam int FW   = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_in,
   input  logic [NREQ*FW-1:0] flit_in,
   input  logic [NREQ-1:0]    en_mask,
   output logic [NREQ-1:0]    ack,
   output logic               tx_req,
   output logic [FW-1:0]      tx_flit,
   input  logic               tx_busy,
   output logic [2:0]         grant_id,
   output logic [15:0]        sent_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

   state_t          r_state;
   logic [2:0]      r_last;
   logic [NREQ-1:0] w_elig;
   logic            w_hit;
   logic [2:0]      w_win;
   logic [3:0]      w_idx;
   logic [FW-1:0]   w_flit;
   logic [NREQ-1:0] w_ack_oh;

   assign w_elig = req_in & en_mask;

   // Search starts one past the last winner and wraps, so each requester waits at most NREQ-1 grants.
   always_comb begin
      w_hit = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = {1'b0, r_last} + 4'(k);
         if (w_idx >= 4'(NREQ)) begin
            w_idx = w_idx - 4'(NREQ);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!w_hit && (w_idx == 4'(i)) && w_elig[i]) begin
               w_hit = 1'b1;
               w_win = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_flit   = '0;
      w_ack_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == 3'(i)) begin
            w_flit = flit_in[i*FW +: FW];
         end
         if (grant_id == 3'(i)) begin
            w_ack_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_last   <= 3'(NREQ - 1);
         tx_req   <= 1'b0;
         tx_flit  <= '0;
         ack      <= '0;
         grant_id <= '0;
         sent_cnt <= '0;
      end else begin
         ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  tx_flit  <= w_flit;
                  grant_id <= w_win;
                  r_last   <= w_win;
                  tx_req   <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!tx_busy) begin
                  ack      <= w_ack_oh;
                  tx_req   <= 1'b0;
                  sent_cnt <= sent_cnt + 16'd1;
                  r_state  <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!tx_busy) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               tx_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule
